// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode with an ID/EX pipeline register.
//   CLK, RST_N            : clock, asynchronous active-low reset
//   if_valid/if_instr/if_pc : fetched instruction; stall asks fetch to hold it
//   flush                 : taken branch/jump resolved in EX, squash decode
//   rs1/rs2, rf_data1/2   : register-file read address/data
//   wb_write/wb_rd/wb_data: writeback port, optionally bypassed into operands
//   ex_*                  : registered ID/EX pipeline outputs
module decode_stage #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        stall,
    input  logic        flush,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    input  logic [31:0] rf_data1,
    input  logic [31:0] rf_data2,
    input  logic        wb_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_op1,
    output logic [31:0] ex_op2,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [6:0]  ex_opcode,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7b5,
    output logic        ex_reg_write,
    output logic        ex_is_load,
    output logic        ex_illegal
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    logic        ex_valid_q,     ex_valid_d;
    logic [31:0] ex_pc_q,        ex_pc_d;
    logic [31:0] ex_op1_q,       ex_op1_d;
    logic [31:0] ex_op2_q,       ex_op2_d;
    logic [31:0] ex_imm_q,       ex_imm_d;
    logic [4:0]  ex_rd_q,        ex_rd_d;
    logic [6:0]  ex_opcode_q,    ex_opcode_d;
    logic [2:0]  ex_funct3_q,    ex_funct3_d;
    logic        ex_funct7b5_q,  ex_funct7b5_d;
    logic        ex_reg_write_q, ex_reg_write_d;
    logic        ex_is_load_q,   ex_is_load_d;
    logic        ex_illegal_q,   ex_illegal_d;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic        legal, use_rs1, use_rs2, writes_rd, is_load;
    logic [31:0] imm;
    logic        hazard;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];

    always_comb begin
        legal     = 1'b1;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        imm       = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                writes_rd = 1'b1;
                imm       = {if_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                writes_rd = 1'b1;
                imm       = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                             if_instr[20], if_instr[30:21], 1'b0};
            end
            OPC_JALR, OPC_OPIMM: begin
                writes_rd = 1'b1;
                use_rs1   = 1'b1;
                imm       = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OPC_LOAD: begin
                writes_rd = 1'b1;
                use_rs1   = 1'b1;
                is_load   = 1'b1;
                imm       = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                           if_instr[30:25], if_instr[11:8], 1'b0};
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Load in EX whose result is needed by the instruction in decode; a
    // flush squashes decode anyway, so it suppresses the stall.
    assign hazard = ex_valid_q && ex_is_load_q && (ex_rd_q != 5'd0) && if_valid &&
                    ((use_rs1 && (ex_rd_q == rs1)) || (use_rs2 && (ex_rd_q == rs2)));
    assign stall  = hazard && !flush;

    always_comb begin
        ex_pc_d        = if_pc;
        ex_imm_d       = imm;
        ex_rd_d        = rd;
        ex_opcode_d    = opcode;
        ex_funct3_d    = if_instr[14:12];
        ex_funct7b5_d  = if_instr[30];
        ex_op1_d       = rf_data1;
        ex_op2_d       = rf_data2;
        if (BYPASS_EN && wb_write && (wb_rd != 5'd0) && (wb_rd == rs1)) ex_op1_d = wb_data;
        if (BYPASS_EN && wb_write && (wb_rd != 5'd0) && (wb_rd == rs2)) ex_op2_d = wb_data;
        ex_valid_d     = 1'b0;
        ex_reg_write_d = 1'b0;
        ex_is_load_d   = 1'b0;
        ex_illegal_d   = 1'b0;
        if (if_valid && !flush && !stall) begin
            ex_valid_d     = 1'b1;
            ex_reg_write_d = legal && writes_rd && (rd != 5'd0);
            ex_is_load_d   = is_load;
            ex_illegal_d   = !legal;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= '0;
            ex_op1_q       <= '0;
            ex_op2_q       <= '0;
            ex_imm_q       <= '0;
            ex_rd_q        <= '0;
            ex_opcode_q    <= '0;
            ex_funct3_q    <= '0;
            ex_funct7b5_q  <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_is_load_q   <= 1'b0;
            ex_illegal_q   <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_pc_q        <= ex_pc_d;
            ex_op1_q       <= ex_op1_d;
            ex_op2_q       <= ex_op2_d;
            ex_imm_q       <= ex_imm_d;
            ex_rd_q        <= ex_rd_d;
            ex_opcode_q    <= ex_opcode_d;
            ex_funct3_q    <= ex_funct3_d;
            ex_funct7b5_q  <= ex_funct7b5_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_is_load_q   <= ex_is_load_d;
            ex_illegal_q   <= ex_illegal_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_pc_q;
    assign ex_op1       = ex_op1_q;
    assign ex_op2       = ex_op2_q;
    assign ex_imm       = ex_imm_q;
    assign ex_rd        = ex_rd_q;
    assign ex_opcode    = ex_opcode_q;
    assign ex_funct3    = ex_funct3_q;
    assign ex_funct7b5  = ex_funct7b5_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_is_load   = ex_is_load_q;
    assign ex_illegal   = ex_illegal_q;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter BYPASS_EN, default 1; when 1, a writeback to the register being read in the same cycle is forwarded into the decode result.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; every flop in the block updates on its rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port if_valid, input, 1 bit: fetch presents an instruction this cycle.
REQ-005 SHALL have ports if_instr and if_pc, input, 32 bits each: the fetched instruction and its PC.
REQ-006 SHALL have port stall, output, 1 bit: when 1, fetch holds if_instr/if_pc stable for the next cycle.
REQ-007 SHALL have port flush, input, 1 bit: a taken branch/jump was resolved in EX.
REQ-008 SHALL have ports rs1 and rs2, output, 5 bits each: register-file read addresses, combinational from if_instr[19:15] and if_instr[24:20].
REQ-009 SHALL have ports rf_data1 and rf_data2, input, 32 bits each: register-file read data (x0 already forced to 0).
REQ-010 SHALL have ports wb_write (1 bit), wb_rd (5 bits) and wb_data (32 bits), inputs: the writeback port driving the register file.
REQ-011 SHALL have ports ex_valid (1), ex_pc (32), ex_op1 (32), ex_op2 (32), ex_imm (32), ex_rd (5), ex_opcode (7), ex_funct3 (3), ex_funct7b5 (1), ex_reg_write (1), ex_is_load (1) and ex_illegal (1), all outputs: the registered ID/EX pipeline register.

Function
REQ-012 SHALL decode the opcode in if_instr[6:0]: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP are legal; any other opcode sets ex_illegal=1 and ex_reg_write=0.
REQ-013 SHALL generate ex_imm by format with sign extension from instr[31]: I (LOAD, OP-IMM, JALR), S (STORE), B (BRANCH, bit0=0), U (LUI, AUIPC, low 12 bits=0), J (JAL, bit0=0); R format gives 0.
REQ-014 SHALL set ex_reg_write=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, except that rd=0 forces ex_reg_write=0.
REQ-015 SHALL treat rs1 as used for JALR, BRANCH, LOAD, STORE, OP-IMM and OP, and rs2 as used for BRANCH, STORE and OP.
REQ-016 SHALL, when BYPASS_EN=1, wb_write=1, wb_rd!=0 and wb_rd equals rs1 (or rs2), take wb_data instead of rf_data1 (or rf_data2) for ex_op1 (or ex_op2).
REQ-017 SHALL drive stall=1 (load-use hazard) when ex_valid=1, ex_is_load=1, ex_rd!=0, if_valid=1, and ex_rd equals a used rs1 or rs2.
REQ-018 SHALL, on a stall cycle, load a bubble (ex_valid=0, ex_reg_write=0, ex_is_load=0) and recompute the held instruction next cycle; a stall lasts exactly one cycle per hazard.
REQ-019 SHALL, on flush=1, load a bubble at the next edge and drive stall=0 that cycle; flush overrides a stall.
REQ-020 SHALL, when if_valid=0 and there is no stall or flush, load a bubble.
REQ-021 SHALL otherwise capture the decoded instruction with ex_valid=1; latency from if_valid to ex_valid is 1 cycle.
REQ-022 SHALL, when ex_valid=0, hold ex_reg_write=0 and ex_is_load=0; the data fields are then don't-care.

Reset
REQ-023 SHALL, while RST_N=0, immediately clear every ex_* output to 0 without waiting for CLK.
REQ-024 SHALL, on reset release, capture at the first CLK edge; a reset asserted mid-stall cancels the stall and the pending bubble.

Verification
REQ-025 ADDI x5,x0,-1 (0xFFF00293) with if_valid=1 -> next cycle ex_valid=1, ex_imm=0xFFFFFFFF, ex_rd=5, ex_reg_write=1.
REQ-026 LW x6,0(x1) followed by ADD x7,x6,x2 -> stall=1 for one cycle, one bubble, then ADD issues with ex_op1 equal to the forwarded wb_data.
REQ-027 wb_write=1, wb_rd=3, wb_data=0x1234, decode ADD x4,x3,x0 with rf_data1=0 -> ex_op1=0x1234; the same case with wb_rd=0 -> ex_op1=0.
REQ-028 A load-use hazard and flush=1 in the same cycle -> stall=0 and ex_valid=0 next cycle.
REQ-029 Opcode 0x7F -> ex_illegal=1, ex_reg_write=0; SW to rd field 0 and BEQ -> ex_reg_write=0 with correct S/B immediates.
REQ-030 RST_N pulsed low between clock edges while ex_valid=1 -> ex_valid=0 immediately.
